// File: rtl/ysyx_22050039_idu_stage.sv
`default_nettype none
// ==========================================================================
// ysyx_22050039_idu_stage : pipelined RV64IM decode stage with GPR file,
// write-back bypass, busy scoreboard and a registered decode->execute slot.
// Rev 1.0 : initial release
// ==========================================================================
module ysyx_22050039_idu_stage #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int NR_REG   = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_src1,
  output logic [XLEN-1:0]     out_src2,
  output logic [XLEN-1:0]     out_imm,
  output logic [REG_SEL-1:0]  out_rd,
  output logic [6:0]          out_type,
  output logic [9:0]          out_funct,
  output logic [6:0]          out_opcode,
  output logic                out_reg_wen,
  output logic                out_pc_wen,
  output logic                out_illegal,
  output logic                out_ebreak,
  input  logic                wb_en,
  input  logic [REG_SEL-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [XLEN-1:0]    imm;
    logic [REG_SEL-1:0] rd;
    logic [6:0]         typ;
    logic [9:0]         funct;
    logic [6:0]         opcode;
    logic               reg_wen;
    logic               pc_wen;
    logic               illegal;
    logic               ebreak;
  } bundle_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [REG_SEL-1:0] rs1;
  logic [REG_SEL-1:0] rs2;
  logic [REG_SEL-1:0] rd;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd     = in_inst[7 +: REG_SEL];
  assign rs1    = in_inst[15 +: REG_SEL];
  assign rs2    = in_inst[20 +: REG_SEL];

  logic is_r, is_i, is_s, is_b, is_u, is_j, is_ebreak, is_jump;
  logic is_special, uses_rs1, uses_rs2, reg_wen;

  always_comb begin
    is_r      = 1'b0;
    is_i      = 1'b0;
    is_s      = 1'b0;
    is_b      = 1'b0;
    is_u      = 1'b0;
    is_j      = 1'b0;
    is_jump   = 1'b0;
    is_ebreak = (in_inst[31:0] == INST_EBREAK);
    case (opcode)
      OP_OP:     is_r = (funct7 == 7'b0000000) || (funct7 == 7'b0000001) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
      OP_OP32:   is_r = (funct7 == 7'b0000000 && (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5)) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) ||
                        (funct7 == 7'b0000001 && (funct3 == 3'd0 || funct3[2]));
      // RV64 shifts carry a 6-bit shamt, so only funct6 is constrained
      OP_IMM:    is_i = (funct3 != 3'd1 && funct3 != 3'd5) ||
                        (funct3 == 3'd1 && in_inst[31:26] == 6'b000000) ||
                        (funct3 == 3'd5 && (in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000));
      OP_IMM32:  is_i = (funct3 == 3'd0) || (funct3 == 3'd1 && funct7 == 7'b0000000) ||
                        (funct3 == 3'd5 && (funct7 == 7'b0000000 || funct7 == 7'b0100000));
      OP_LOAD:   is_i = (funct3 != 3'd7);
      OP_JALR: begin
        is_i    = (funct3 == 3'd0);
        is_jump = (funct3 == 3'd0);
      end
      OP_STORE:  is_s = !funct3[2];
      OP_BRANCH: begin
        is_b    = (funct3 != 3'd2 && funct3 != 3'd3);
        is_jump = (funct3 != 3'd2 && funct3 != 3'd3);
      end
      OP_LUI, OP_AUIPC: is_u = 1'b1;
      OP_JAL: begin
        is_j    = 1'b1;
        is_jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_special = !(is_r || is_i || is_s || is_b || is_u || is_j);
  assign uses_rs1   = is_r || is_i || is_s || is_b;
  assign uses_rs2   = is_r || is_s || is_b;
  assign reg_wen    = (is_r || is_i || is_u || is_j) && (rd != '0);

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;

  always_comb begin
    imm32 = '0;
    if (is_i)      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (is_s) imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (is_b) imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_u) imm32 = {in_inst[31:12], 12'b0};
    else if (is_j) imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  end

  assign imm = XLEN'($signed(imm32));

  // GPR file and scoreboard state
  logic [XLEN-1:0]   gpr_q [NR_REG];
  logic [XLEN-1:0]   gpr_d [NR_REG];
  logic [NR_REG-1:0] busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  bundle_t           bundle_q, bundle_d, dec;

  logic [XLEN-1:0] rdata1, rdata2;

  always_comb begin
    rdata1 = gpr_q[rs1];
    if (wb_en && wb_rd == rs1) rdata1 = wb_data;
    if (rs1 == '0)             rdata1 = '0;
    rdata2 = gpr_q[rs2];
    if (wb_en && wb_rd == rs2) rdata2 = wb_data;
    if (rs2 == '0)             rdata2 = '0;
  end

  // A write-back landing this cycle releases the register it clears
  logic hazard, fire;

  assign hazard = (uses_rs1 && busy_q[rs1] && !(wb_en && wb_rd == rs1)) ||
                  (uses_rs2 && busy_q[rs2] && !(wb_en && wb_rd == rs2)) ||
                  (reg_wen  && busy_q[rd]  && !(wb_en && wb_rd == rd));

  assign in_ready = rst && !hazard && (!out_valid_q || out_ready) && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.src1    = uses_rs1 ? rdata1 : (is_u ? imm : '0);
    dec.src2    = uses_rs2 ? rdata2 : '0;
    dec.imm     = imm;
    dec.rd      = rd;
    dec.typ     = {is_r, is_i, is_s, is_b, is_u, is_j, is_special};
    dec.funct   = (is_r || is_i || is_s || is_b) ? {funct7, funct3} : 10'd0;
    dec.opcode  = opcode;
    dec.reg_wen = reg_wen;
    dec.pc_wen  = is_jump;
    dec.illegal = is_special && !is_ebreak;
    dec.ebreak  = is_ebreak;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (fire) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clears first, then a set from the issuing instruction overrides them
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (flush && out_valid_q && bundle_q.reg_wen) busy_d[bundle_q.rd] = 1'b0;
    if (fire && reg_wen) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    gpr_d = gpr_q;
    if (wb_en && wb_rd != '0) gpr_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      busy_q      <= '0;
      gpr_q       <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      busy_q      <= busy_d;
      gpr_q       <= gpr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = bundle_q.pc;
  assign out_src1    = bundle_q.src1;
  assign out_src2    = bundle_q.src2;
  assign out_imm     = bundle_q.imm;
  assign out_rd      = bundle_q.rd;
  assign out_type    = bundle_q.typ;
  assign out_funct   = bundle_q.funct;
  assign out_opcode  = bundle_q.opcode;
  assign out_reg_wen = bundle_q.reg_wen;
  assign out_pc_wen  = bundle_q.pc_wen;
  assign out_illegal = bundle_q.illegal;
  assign out_ebreak  = bundle_q.ebreak;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_idu_stage.sv
`default_nettype none
// ==========================================================================
// tb_ysyx_22050039_idu_stage : directed bench with a behavioural decode model
// Rev 1.0 : initial release
// ==========================================================================
module tb_ysyx_22050039_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc, out_src1, out_src2, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_type;
  logic [9:0]  out_funct;
  logic [6:0]  out_opcode;
  logic        out_reg_wen, out_pc_wen, out_illegal, out_ebreak;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;

  ysyx_22050039_idu_stage #(.XLEN(64), .INST_LEN(32), .NR_REG(32), .REG_SEL(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_rd(out_rd),
    .out_type(out_type), .out_funct(out_funct), .out_opcode(out_opcode),
    .out_reg_wen(out_reg_wen), .out_pc_wen(out_pc_wen),
    .out_illegal(out_illegal), .out_ebreak(out_ebreak),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SP = 3'd6;

  typedef struct packed {
    logic        valid;
    logic [2:0]  fmt;
    logic [63:0] pc, src1, src2, imm;
    logic [4:0]  rd;
    logic [6:0]  typ;
    logic [9:0]  funct;
    logic [6:0]  opcode;
    logic        reg_wen, pc_wen, illegal, ebreak;
  } bundle_t;

  logic [63:0] m_gpr [32] = '{default: '0};
  logic [31:0] m_busy = '0;
  bundle_t     m_slot = '0;

  function automatic logic [63:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_gpr[r];
  endfunction

  function automatic bundle_t mdec(input logic [31:0] i, input logic [63:0] pc);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    longint s;
    b = '0;
    op = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    s = $signed(i);
    b.fmt = F_SP;
    case (op)
      7'h33: if (f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5})) b.fmt = F_R;
      7'h3B: if ((f7 == 7'h00 && f3 inside {3'd0, 3'd1, 3'd5}) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
                 (f7 == 7'h01 && !(f3 inside {3'd1, 3'd2, 3'd3}))) b.fmt = F_R;
      7'h13: if (f3 == 3'd1 ? (i[31:26] == 6'h00) : (f3 == 3'd5 ? (i[31:26] inside {6'h00, 6'h10}) : 1'b1)) b.fmt = F_I;
      7'h1B: if (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) || (f3 == 3'd5 && f7 inside {7'h00, 7'h20})) b.fmt = F_I;
      7'h03: if (f3 != 3'd7) b.fmt = F_I;
      7'h67: if (f3 == 3'd0) b.fmt = F_I;
      7'h23: if (f3 < 3'd4) b.fmt = F_S;
      7'h63: if (!(f3 inside {3'd2, 3'd3})) b.fmt = F_B;
      7'h37, 7'h17: b.fmt = F_U;
      7'h6F: b.fmt = F_J;
      default: ;
    endcase
    case (b.fmt)
      F_I: b.imm = s >>> 20;
      F_S: b.imm = (s >>> 25) * 32 + longint'(i[11:7]);
      F_B: b.imm = (s >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      F_U: b.imm = (s >>> 12) * 4096;
      F_J: b.imm = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      default: b.imm = 64'd0;
    endcase
    b.valid   = 1'b1;
    b.pc      = pc;
    b.rd      = i[11:7];
    b.opcode  = op;
    b.typ     = 7'b1000000 >> b.fmt;
    b.funct   = (b.fmt <= F_B) ? {f7, f3} : 10'd0;
    b.ebreak  = (i == 32'h0010_0073);
    b.illegal = (b.fmt == F_SP) && !b.ebreak;
    b.reg_wen = (b.fmt inside {F_R, F_I, F_U, F_J}) && (b.rd != 5'd0);
    b.pc_wen  = (op inside {7'h6F, 7'h67, 7'h63}) && (b.fmt != F_SP);
    b.src1    = (b.fmt <= F_B) ? mread(i[19:15]) : ((b.fmt == F_U) ? b.imm : 64'd0);
    b.src2    = (b.fmt inside {F_R, F_S, F_B}) ? mread(i[24:20]) : 64'd0;
    return b;
  endfunction

  function automatic logic m_ready();
    bundle_t b;
    logic haz;
    b = mdec(in_inst, in_pc);
    haz = 1'b0;
    if (b.fmt <= F_B && m_busy[in_inst[19:15]] && !(wb_en && wb_rd == in_inst[19:15])) haz = 1'b1;
    if (b.fmt inside {F_R, F_S, F_B} && m_busy[in_inst[24:20]] && !(wb_en && wb_rd == in_inst[24:20])) haz = 1'b1;
    if (b.reg_wen && m_busy[b.rd] && !(wb_en && wb_rd == b.rd)) haz = 1'b1;
    return rst && !haz && (!m_slot.valid || out_ready) && !flush;
  endfunction

  function automatic logic [31:0] m_next_busy();
    logic [31:0] b;
    bundle_t d;
    b = m_busy;
    if (wb_en) b[wb_rd] = 1'b0;
    if (flush && m_slot.valid && m_slot.reg_wen) b[m_slot.rd] = 1'b0;
    d = mdec(in_inst, in_pc);
    if (in_valid && m_ready() && d.reg_wen) b[d.rd] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot <= '0;
      m_busy <= '0;
      for (int k = 0; k < 32; k++) m_gpr[k] <= '0;
    end else begin
      m_busy <= m_next_busy();
      if (wb_en && wb_rd != 5'd0) m_gpr[wb_rd] <= wb_data;
      if (in_valid && m_ready()) m_slot <= mdec(in_inst, in_pc);
      else if (flush || out_ready) m_slot.valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready()});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_slot.valid});
      chk("busy", {32'd0, dut.busy_q}, {32'd0, m_busy});
      if (m_slot.valid) begin
        chk("out_pc", out_pc, m_slot.pc);
        chk("out_src1", out_src1, m_slot.src1);
        chk("out_src2", out_src2, m_slot.src2);
        chk("out_imm", out_imm, m_slot.imm);
        chk("out_rd", {59'd0, out_rd}, {59'd0, m_slot.rd});
        chk("out_type", {57'd0, out_type}, {57'd0, m_slot.typ});
        chk("out_funct", {54'd0, out_funct}, {54'd0, m_slot.funct});
        chk("out_opcode", {57'd0, out_opcode}, {57'd0, m_slot.opcode});
        chk("out_flags", {60'd0, out_reg_wen, out_pc_wen, out_illegal, out_ebreak},
            {60'd0, m_slot.reg_wen, m_slot.pc_wen, m_slot.illegal, m_slot.ebreak});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 13;
  logic [31:0] v_inst [NV] = '{32'hFE20BC23, 32'hFE208EE3, 32'h001000EF, 32'h00008067,
                               32'hFFFFF417, 32'h022084B3, 32'h4030D51B, 32'h01013583,
                               32'hFFFFFFFF, 32'h00100073, 32'hFFF00613, 32'h402086BB,
                               32'h03F09713};
  logic [63:0] v_imm  [NV] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h800, 64'h0,
                               64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'h403, 64'h10,
                               64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h3F};
  logic [6:0]  v_typ  [NV] = '{7'b0010000, 7'b0001000, 7'b0000010, 7'b0100000,
                               7'b0000100, 7'b1000000, 7'b0100000, 7'b0100000,
                               7'b0000001, 7'b0000001, 7'b0100000, 7'b1000000,
                               7'b0100000};

  initial begin
    logic [4:0] pr;
    logic       fired;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {32'd0, dut.busy_q}, 64'd0);

    // addi x1,x0,5
    in_inst = 32'h00500093; in_pc = 64'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_type", {57'd0, out_type}, 64'h20);
    chk("addi_src1", out_src1, 64'd0);
    chk("addi_imm", out_imm, 64'd5);
    chk("addi_rd", {59'd0, out_rd}, 64'd1);
    chk("addi_busy1", {63'd0, dut.busy_q[1]}, 64'd1);

    // add x2,x1,x1 stalls until x1 writes back
    in_inst = 32'h00108133; in_pc = 64'h8000_0004; in_valid = 1'b1;
    #1 chk("raw_stall0", {63'd0, in_ready}, 64'd0);
    step();
    chk("raw_stall1", {63'd0, in_ready}, 64'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h5;
    #1 chk("raw_release", {63'd0, in_ready}, 64'd1);
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("add_src1", out_src1, 64'h5);
    chk("add_src2", out_src2, 64'h5);

    // back-pressure: slot holds for 3 cycles
    out_ready = 1'b0;
    in_inst = 32'h00700313; in_pc = 64'h8000_0008; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("hold_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_rd", {59'd0, out_rd}, 64'd2);
      chk("hold_src1", out_src1, 64'h5);
    end
    out_ready = 1'b1;
    #1 chk("hold_release", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("next_rd", {59'd0, out_rd}, 64'd6);
    chk("next_imm", out_imm, 64'd7);

    // write-back to x0 is discarded
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF;
    in_inst = 32'h000001B3; in_pc = 64'h8000_000C; in_valid = 1'b1;
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("x0_src1", out_src1, 64'd0);
    chk("x0_src2", out_src2, 64'd0);

    // lui x5 then flush
    in_inst = 32'h123452B7; in_pc = 64'h8000_0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lui_src1", out_src1, 64'h1234_5000);
    chk("lui_busy5", {63'd0, dut.busy_q[5]}, 64'd1);
    flush = 1'b1;
    #1 chk("flush_ready", {63'd0, in_ready}, 64'd0);
    step();
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_busy5", {63'd0, dut.busy_q[5]}, 64'd0);
    in_inst = 32'h00128393; in_pc = 64'h8000_0014; in_valid = 1'b1;
    #1 chk("after_flush_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("after_flush_valid", {63'd0, out_valid}, 64'd1);

    // instruction class sweep with a rotating write-back to drain hazards
    pr = 5'd1;
    for (int k = 0; k < NV; k++) begin
      in_inst = v_inst[k]; in_pc = 64'h8000_0100 + 64'(k) * 4; in_valid = 1'b1;
      fired = 1'b0;
      for (int n = 0; n < 40 && !fired; n++) begin
        #1;
        if (in_ready) fired = 1'b1;
        step();
        if (!fired) begin
          wb_en = 1'b1; wb_rd = pr; wb_data = {$urandom, $urandom};
          pr = (pr == 5'd31) ? 5'd1 : pr + 5'd1;
        end
      end
      in_valid = 1'b0;
      chk("vec_fire", {63'd0, fired}, 64'd1);
      chk("vec_imm", out_imm, v_imm[k]);
      chk("vec_type", {57'd0, out_type}, {57'd0, v_typ[k]});
    end
    wb_en = 1'b0;

    // asynchronous reset while the slot is full
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #3 rst = 1'b0;
    #1 chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_busy", {32'd0, dut.busy_q}, 64'd0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22050039_idu_stage.md
Name: ysyx_22050039_idu_stage

Overview:
Pipelined successor of the single-cycle decode unit. It accepts fetched instructions over a valid/ready handshake and decodes the RV64IM instruction classes (R/I/S/B/U/J/special). It reads operands from an internal parametrised GPR file with a write-back bypass, and tracks pending writes with a scoreboard that stalls on RAW/WAW hazards. Results are held in a registered decode→execute output slot between IFU and EXU.

Parameters:
XLEN, 64, GPR and operand width (32 or 64)
INST_LEN, 32, instruction width
NR_REG, 32, number of GPRs (16 for RV-E, or 32)
REG_SEL, 5, register index width; equals clog2(NR_REG)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  fetched instruction valid
in_ready  out  1  stage can accept the instruction
in_inst  in  INST_LEN  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts the bundle
out_pc  out  XLEN  registered PC
out_src1  out  XLEN  rs1 operand; U-type: upper immediate; J-type: 0
out_src2  out  XLEN  rs2 operand
out_imm  out  XLEN  sign-extended immediate for the instruction format
out_rd  out  REG_SEL  destination register
out_type  out  7  one-hot {R,I,S,B,U,J,SPECIAL}
out_funct  out  10  {funct7, funct3}; 0 for U, J and SPECIAL
out_opcode  out  7  opcode
out_reg_wen  out  1  instruction writes rd (rd≠0)
out_pc_wen  out  1  jal/jalr/branch
out_illegal  out  1  no pattern matched
out_ebreak  out  1  ebreak
wb_en  in  1  write-back strobe
wb_rd  in  REG_SEL  write-back index
wb_data  in  XLEN  write-back data
flush  in  1  kill the output slot (redirect)

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; all busy bits=0; all GPRs=0; all out_* data fields=0. Releasing reset mid-handshake leaves no stale valid.
- GPR file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes occur on the clk edge when wb_en=1.
- Decode: purely combinational from in_inst. Decodes the same instruction set and immediate formats as the current decoder.
  - Immediate sign extension is to XLEN.
  - B and J immediates include the low 0 bit.
  - Unmatched instructions give SPECIAL with out_illegal=1.
- Operand read:
  - Same-cycle bypass: if wb_en && wb_rd==rs && rs≠0, the read returns wb_data.
  - Only fields used by the format are considered: rs1 for R/I/S/B; rs2 for R/S/B.
- Scoreboard: busy[NR_REG], with busy[0] always 0.
  - hazard = (uses_rs1 && busy[rs1] && !(wb_en && wb_rd==rs1)) || (same check for rs2) || (reg_wen && busy[rd] && !(wb_en && wb_rd==rd)).
- Handshake:
  - in_ready = rst && !hazard && (!out_valid || out_ready) && !flush.
  - Fire = in_valid && in_ready. On fire, the output slot loads at the next edge and out_valid=1.
  - If the slot drains (out_valid && out_ready) without a fire, out_valid becomes 0.
  - Latency is 1 cycle from fire to out_valid. Throughput is 1 per cycle when there are no hazards.
  - Output fields are stable while out_valid && !out_ready.
- Busy update each edge, in priority order:
  - Clear busy[wb_rd] on wb_en.
  - Then set busy[rd] on fire with reg_wen. Set wins over clear when the index is the same.
- flush:
  - out_valid becomes 0 at the next edge.
  - If the slot held reg_wen, that slot's rd busy bit is cleared.
  - No fire occurs in the flush cycle.
  - Busy bits for instructions already past the slot are unaffected and are cleared by their write-back.
- ebreak and illegal instructions pass through as normal bundles with reg_wen=0.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) with in_valid=1 and out_ready=1 → out_valid=1 one cycle later; out_type=I; out_src1=0; out_imm=5; out_rd=1; busy[1]=1.
- With busy[1] set, add x2,x1,x1 is presented → in_ready=0 until wb_en=1, wb_rd=1, wb_data=0x5. In that cycle it fires; next cycle out_src1=out_src2=0x5.
- out_ready=0 for 3 cycles with a second instruction waiting → in_ready=0 and the out_* fields hold unchanged. On out_ready=1, the next bundle appears the following cycle.
- Write-back to x0 with wb_data=0xFFFF, then add x3,x0,x0 → out_src1=out_src2=0.
- Fire lui x5,0x12345 and assert flush the cycle after → out_valid=0 and busy[5]=0; a following instruction reading x5 issues without stall.
- Apply rst=0 asynchronously while out_valid=1 → out_valid drops immediately; after release, in_ready=1 and no busy bits are set.
